// File: rtl/sha256_pkg.sv
// sha256_pkg
//   Shared definitions for the SHA-256/SHA-224 streaming core:
//   round constants, initial hash values for both modes, the control
//   FSM state type and the SHA-2 bitwise helper functions.
package sha256_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ROUNDS = 2'd1,
        S_UPDATE = 2'd2,
        S_OUTPUT = 2'd3
    } state_e;

    localparam logic [31:0] SHA_K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] SHA256_IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] SHA224_IV [0:7] = '{
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic [31:0] Sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] Sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Initial hash word idx for the selected mode (1 = SHA-224).
    function automatic logic [31:0] iv_word(input logic sha224, input logic [2:0] idx);
        return sha224 ? SHA224_IV[idx] : SHA256_IV[idx];
    endfunction

endpackage

// File: rtl/sha256_round.sv
// sha256_round
//   One purely combinational SHA-2 compression round.
//   Ports: a_i..h_i  current working variables
//          k_i       round constant
//          w_i       message schedule word for this round
//          a_o..h_o  working variables after the round
module sha256_round
    import sha256_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [31:0] c_i,
    input  logic [31:0] d_i,
    input  logic [31:0] e_i,
    input  logic [31:0] f_i,
    input  logic [31:0] g_i,
    input  logic [31:0] h_i,
    input  logic [31:0] k_i,
    input  logic [31:0] w_i,
    output logic [31:0] a_o,
    output logic [31:0] b_o,
    output logic [31:0] c_o,
    output logic [31:0] d_o,
    output logic [31:0] e_o,
    output logic [31:0] f_o,
    output logic [31:0] g_o,
    output logic [31:0] h_o
);

    logic [31:0] t1;
    logic [31:0] t2;

    assign t1  = h_i + Sigma1(e_i) + ch(e_i, f_i, g_i) + k_i + w_i;
    assign t2  = Sigma0(a_i) + maj(a_i, b_i, c_i);

    assign a_o = t1 + t2;
    assign b_o = a_i;
    assign c_o = b_i;
    assign d_o = c_i;
    assign e_o = d_i + t1;
    assign f_o = e_i;
    assign g_o = f_i;
    assign h_o = g_i;

endmodule

// File: rtl/sha256_stream_core.sv
// sha256_stream_core
//   Multi-block SHA-256 / SHA-224 compression engine. Accepts padded
//   512-bit blocks, chains the intermediate hash across blocks and
//   presents the digest after the block marked last.
//   Ports: clk, rst (sync, active-high), ena (clock enable)
//          block_data/block_valid/block_last/mode/block_ready  block input
//          hash_data/hash_valid/hash_ready                     digest output
//   ROUNDS_PER_CYCLE (1, 2 or 4) rounds are evaluated each cycle.
module sha256_stream_core
    import sha256_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic [511:0] block_data,
    input  logic         block_valid,
    input  logic         block_last,
    input  logic         mode,
    output logic         block_ready,
    output logic [255:0] hash_data,
    output logic         hash_valid,
    input  logic         hash_ready
);

    localparam int R = ROUNDS_PER_CYCLE;

    if (!(R == 1 || R == 2 || R == 4)) begin : g_bad_rounds
        $error("sha256_stream_core: ROUNDS_PER_CYCLE must be 1, 2 or 4");
    end

    state_e      state_q, state_d;
    logic [31:0] h_q  [8];
    logic [31:0] h_d  [8];
    logic [31:0] wv_q [8];
    logic [31:0] wv_d [8];
    logic [31:0] w_q  [16];
    logic [31:0] w_d  [16];
    logic [5:0]  round_q, round_d;
    logic        first_q, first_d;
    logic        mode_q, mode_d;
    logic        last_q, last_d;

    logic [31:0] w_rnd   [R];
    logic [31:0] w_shift [16];
    logic [31:0] wv_rnd  [8];

    // Rolling schedule: w_q[0] is W[round]. Extend the window by R words
    // (each new word may depend on the one just generated), feed the first
    // R words to the rounds and slide the window forward by R.
    always_comb begin : sched
        logic [31:0] ext [16+R];
        for (int i = 0; i < 16; i++) begin
            ext[i] = w_q[i];
        end
        for (int j = 16; j < 16 + R; j++) begin
            ext[j] = sigma1(ext[j-2]) + ext[j-7] + sigma0(ext[j-15]) + ext[j-16];
        end
        for (int i = 0; i < R; i++) begin
            w_rnd[i] = ext[i];
        end
        for (int i = 0; i < 16; i++) begin
            w_shift[i] = ext[i+R];
        end
    end

    // Chain of R combinational rounds starting from the working registers.
    for (genvar r = 0; r < R; r++) begin : g_rnd
        logic [31:0] in_v  [8];
        logic [31:0] out_v [8];

        if (r == 0) begin : g_head
            assign in_v = wv_q;
        end else begin : g_link
            assign in_v = g_rnd[r-1].out_v;
        end

        sha256_round u_round (
            .a_i (in_v[0]),
            .b_i (in_v[1]),
            .c_i (in_v[2]),
            .d_i (in_v[3]),
            .e_i (in_v[4]),
            .f_i (in_v[5]),
            .g_i (in_v[6]),
            .h_i (in_v[7]),
            .k_i (SHA_K[round_q + 6'(r)]),
            .w_i (w_rnd[r]),
            .a_o (out_v[0]),
            .b_o (out_v[1]),
            .c_o (out_v[2]),
            .d_o (out_v[3]),
            .e_o (out_v[4]),
            .f_o (out_v[5]),
            .g_o (out_v[6]),
            .h_o (out_v[7])
        );
    end

    assign wv_rnd = g_rnd[R-1].out_v;

    // SHA-224 truncates to seven words; the unused low word reads as zero.
    assign hash_data = {h_q[0], h_q[1], h_q[2], h_q[3], h_q[4], h_q[5], h_q[6],
                        mode_q ? 32'h0 : h_q[7]};

    always_comb begin
        state_d     = state_q;
        h_d         = h_q;
        wv_d        = wv_q;
        w_d         = w_q;
        round_d     = round_q;
        first_d     = first_q;
        mode_d      = mode_q;
        last_d      = last_q;
        block_ready = 1'b0;
        hash_valid  = 1'b0;

        case (state_q)
            S_IDLE: begin
                block_ready = ena && !rst;
                if (block_valid && block_ready) begin
                    for (int i = 0; i < 16; i++) begin
                        w_d[i] = block_data[511 - 32*i -: 32];
                    end
                    if (first_q) begin
                        // New message: mode is only honoured here.
                        mode_d  = mode;
                        first_d = 1'b0;
                        for (int i = 0; i < 8; i++) begin
                            h_d[i]  = iv_word(mode, 3'(i));
                            wv_d[i] = iv_word(mode, 3'(i));
                        end
                    end else begin
                        wv_d = h_q;
                    end
                    last_d  = block_last;
                    round_d = 6'd0;
                    state_d = S_ROUNDS;
                end
            end

            S_ROUNDS: begin
                wv_d    = wv_rnd;
                w_d     = w_shift;
                round_d = round_q + 6'(R);
                if (round_q == 6'(64 - R)) begin
                    state_d = S_UPDATE;
                end
            end

            S_UPDATE: begin
                for (int i = 0; i < 8; i++) begin
                    h_d[i] = h_q[i] + wv_q[i];
                end
                state_d = last_q ? S_OUTPUT : S_IDLE;
            end

            S_OUTPUT: begin
                hash_valid = ena && !rst;
                if (hash_valid && hash_ready) begin
                    first_d = 1'b1;
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else if (ena) begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                h_q[i]  <= 32'h0;
                wv_q[i] <= 32'h0;
            end
            for (int i = 0; i < 16; i++) begin
                w_q[i] <= 32'h0;
            end
            round_q <= 6'd0;
            first_q <= 1'b1;
            mode_q  <= 1'b0;
            last_q  <= 1'b0;
        end else if (ena) begin
            h_q     <= h_d;
            wv_q    <= wv_d;
            w_q     <= w_d;
            round_q <= round_d;
            first_q <= first_d;
            mode_q  <= mode_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_sha256_stream_core.sv
// tb_sha256_stream_core
//   Drives three instances (1, 2 and 4 rounds per cycle) with known
//   messages. Expected digests and latencies go into a scoreboard when
//   the final block is accepted and are checked when hash_valid rises.
module tb_sha256_stream_core;

    localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] BLK_TWO_1 = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] BLK_TWO_2 = {480'h0, 32'h000001c0};

    localparam logic [255:0] DIG_ABC256 =
        256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] DIG_ABC224 =
        256'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7_00000000;
    localparam logic [255:0] DIG_TWO =
        256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
    localparam logic [255:0] DIG_EMPTY =
        256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;

    typedef struct {
        int           dut;
        logic [255:0] digest;
        int           acc_cyc;
        int           lat;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         ena;
    logic [511:0] bdata  [3];
    logic         bvalid [3];
    logic         blast  [3];
    logic         bmode  [3];
    logic         bready [3];
    logic [255:0] hdata  [3];
    logic         hvalid [3];
    logic         hready [3];

    exp_t sb [$];
    exp_t e;
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_dig    = 0;
    bit   hv_prev [3];

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        sha256_stream_core #(.ROUNDS_PER_CYCLE(1 << gi)) u_dut (
            .clk         (clk),
            .rst         (rst),
            .ena         (ena),
            .block_data  (bdata[gi]),
            .block_valid (bvalid[gi]),
            .block_last  (blast[gi]),
            .mode        (bmode[gi]),
            .block_ready (bready[gi]),
            .hash_data   (hdata[gi]),
            .hash_valid  (hvalid[gi]),
            .hash_ready  (hready[gi])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [255:0] got,
                             input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: compare on every rising edge of hash_valid.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (hvalid[d] && !hv_prev[d]) begin
                n_dig++;
                if (sb.size() == 0) begin
                    check_val($sformatf("unexpected_digest_d%0d", d), 256'd1, 256'd0);
                end else begin
                    e = sb.pop_front();
                    check_val("digest_dut", 256'(d), 256'(e.dut));
                    check_val($sformatf("digest_r%0d", 1 << d), hdata[d], e.digest);
                    check_val($sformatf("latency_r%0d", 1 << d),
                              256'(cyc - e.acc_cyc), 256'(e.lat));
                end
            end
            hv_prev[d] = hvalid[d];
        end
    end

    task automatic send_block(input int d, input logic [511:0] data, input logic last,
                              input logic md, input logic [255:0] dig, input int lat);
        int t = 0;
        @(negedge clk);
        while (!bready[d] && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!bready[d]) begin
            check_val("block_ready_timeout", 256'd0, 256'd1);
            return;
        end
        bdata[d]  = data;
        blast[d]  = last;
        bmode[d]  = md;
        bvalid[d] = 1'b1;
        @(posedge clk);
        #1;
        bvalid[d] = 1'b0;
        if (last) sb.push_back('{d, dig, cyc, lat});
    endtask

    task automatic wait_done(input int d);
        int t = 0;
        while ((sb.size() != 0 || hvalid[d]) && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0 || hvalid[d]) begin
            check_val("digest_timeout", 256'd0, 256'd1);
            sb.delete();
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [255:0] held;
        int           t;
        int           lat;

        rst = 1'b1;
        ena = 1'b1;
        for (int d = 0; d < 3; d++) begin
            bdata[d]  = '0;
            bvalid[d] = 1'b0;
            blast[d]  = 1'b0;
            bmode[d]  = 1'b0;
            hready[d] = 1'b1;
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check_val("reset_block_ready", 256'(bready[d]), 256'd0);
            check_val("reset_hash_valid", 256'(hvalid[d]), 256'd0);
            check_val("reset_hash_data", hdata[d], 256'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check_val("idle_block_ready", 256'(bready[d]), 256'd1);
        end

        // SHA-256 "abc", SHA-224 "abc", two-block message for each R.
        for (int d = 0; d < 3; d++) begin
            lat = (64 >> d) + 1;
            send_block(d, BLK_ABC, 1'b1, 1'b0, DIG_ABC256, lat);
            wait_done(d);
            send_block(d, BLK_ABC, 1'b1, 1'b1, DIG_ABC224, lat);
            wait_done(d);
            send_block(d, BLK_TWO_1, 1'b0, 1'b0, DIG_TWO, lat);
            send_block(d, BLK_TWO_2, 1'b1, 1'b1, DIG_TWO, lat);
            wait_done(d);
        end

        // Empty message with the consumer stalling for 10 cycles.
        hready[0] = 1'b0;
        send_block(0, BLK_EMPTY, 1'b1, 1'b0, DIG_EMPTY, 65);
        t = 0;
        while (!hvalid[0] && t < 200) begin
            @(negedge clk);
            t++;
        end
        check_val("empty_hash_valid_rise", 256'(hvalid[0]), 256'd1);
        held = hdata[0];
        repeat (10) begin
            @(negedge clk);
            check_val("stall_hash_valid", 256'(hvalid[0]), 256'd1);
            check_val("stall_hash_data", hdata[0], held);
            check_val("stall_block_ready", 256'(bready[0]), 256'd0);
        end
        hready[0] = 1'b1;
        wait_done(0);

        // Clock-enable pause of 5 cycles in the middle of the rounds.
        send_block(0, BLK_ABC, 1'b1, 1'b0, DIG_ABC256, 70);
        repeat (10) @(negedge clk);
        ena = 1'b0;
        #1;
        check_val("ena_low_block_ready_idle_dut", 256'(bready[1]), 256'd0);
        check_val("ena_low_hash_valid", 256'(hvalid[0]), 256'd0);
        repeat (5) @(negedge clk);
        ena = 1'b1;
        wait_done(0);

        // Reset in the middle of a message, then a fresh single-block message.
        send_block(0, BLK_TWO_1, 1'b0, 1'b0, DIG_TWO, 65);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_val("midreset_block_ready", 256'(bready[0]), 256'd0);
        check_val("midreset_hash_data", hdata[0], 256'd0);
        rst = 1'b0;
        send_block(0, BLK_ABC, 1'b1, 1'b0, DIG_ABC256, 65);
        wait_done(0);

        repeat (3) @(negedge clk);
        check_val("digest_count", 256'(n_dig), 256'd12);
        check_val("scoreboard_empty", 256'(sb.size()), 256'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sha256_stream_core.md
Name: sha256_stream_core

Overview:
Multi-block SHA-256/SHA-224 compression engine. It accepts pre-padded 512-bit message blocks over a valid/ready handshake and chains the intermediate hash across blocks until a block flagged last arrives, then presents the digest over a second valid/ready handshake. It sits between the message padder (upstream) and the digest consumer (downstream). It generalises the single-block accelerator with multi-block chaining, selectable SHA-224 mode, backpressure, and a configurable number of rounds per cycle.

Parameters:
ROUNDS_PER_CYCLE, 1, compression rounds unrolled per clock; legal values 1, 2, 4; any other value is an elaboration error.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
ena  input  1  clock enable; when 0 all state freezes
block_data  input  512  padded block; [511:480] = W0, big-endian 32-bit words
block_valid  input  1  block_data, block_last and mode are valid
block_last  input  1  final block of the current message
mode  input  1  0 = SHA-256, 1 = SHA-224; sampled only on the first block of a message
block_ready  output  1  core can accept a block
hash_data  output  256  digest {H0..H7}; in SHA-224 mode {H0..H6, 32'h0}
hash_valid  output  1  digest valid; held until accepted
hash_ready  input  1  downstream accepts the digest

Behaviour:
- Reset (rst=1 at a clk edge, with priority over ena): state is S_IDLE; block_ready=0 during reset, then 1 in S_IDLE; hash_valid=0; hash_data=0; H and working registers are cleared; the first-block flag is set to 1; the schedule index is 0.
- ena=0: no register changes; block_ready and hash_valid are driven 0 combinationally; hash_data holds its value.
- FSM states: S_IDLE, S_ROUNDS, S_UPDATE, S_OUTPUT.
- S_IDLE: block_ready=1. A block is accepted on any edge where block_valid && block_ready && ena. On acceptance:
  - W[0:15] is loaded from block_data.
  - If the first-block flag is 1: latch mode; load H and a..h with the mode's IV (SHA-256: 6a09e667…5be0cd19; SHA-224: c1059ed8…befa4fa4); clear the first-block flag.
  - Otherwise: a..h are loaded from H.
  - Latch block_last; set round=0; go to S_ROUNDS.
- S_ROUNDS: performs ROUNDS_PER_CYCLE consecutive rounds per cycle using K[round..]. The message schedule is a rolling 16-word window; W[t] for t≥16 is computed on the fly using sigma0 = ROTR7^ROTR18^SHR3 and sigma1 = ROTR17^ROTR19^SHR10. round increments by ROUNDS_PER_CYCLE. When round+ROUNDS_PER_CYCLE==64, go to S_UPDATE. This state lasts exactly 64/ROUNDS_PER_CYCLE cycles.
- S_UPDATE (1 cycle): Hi <= Hi + working var, mod 2^32 per word.
  - If latched last: go to S_OUTPUT.
  - Otherwise: go to S_IDLE.
- S_OUTPUT: hash_valid=1 and hash_data is stable. On hash_valid && hash_ready: go to S_IDLE, set the first-block flag, drop hash_valid on the next cycle. block_ready=0 in this state.
- Latency: the last block accepted at edge N gives hash_valid=1 after edge N+64/R+1, where R = ROUNDS_PER_CYCLE. Minimum spacing between accepted blocks is 64/R+2 cycles.
- Arithmetic: all adds are 32-bit modulo; carries are discarded.
- Mode changes on non-first blocks are ignored.
- block_valid/block_last are don't-care outside S_IDLE.
- Reset mid-message: the partial message is discarded and the next accepted block is treated as first.

Decomposition:
- Package sha256_pkg holds:
  - K[0:63] constant array;
  - SHA-256 and SHA-224 IV arrays;
  - state enum;
  - functions ch, maj, Sigma0, Sigma1, sigma0, sigma1.
- One sub-module, sha256_round: purely combinational single round. Inputs: a..h, K, W. Output: next a..h. It is instantiated ROUNDS_PER_CYCLE times in a chain.
- The rolling schedule window stays in the top module.

Test Plan:
1. SHA-256 "abc": one block 61626380_0…0_00000018, last=1, mode=0. Required digest: ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad. With R=1, hash_valid rises 65 cycles after acceptance.
2. SHA-224 "abc": same block, mode=1. Required digest: 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7, with low 32 bits of hash_data = 0.
3. Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmjklmnklmnlmnomnopnopq" (last=0 then last=1; mode=1 on block 2 is ignored). Required digest: 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
4. Empty message: block 80000000_0…0. Required digest: e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855. Hold hash_ready=0 for 10 cycles: hash_valid and hash_data must stay stable and block_ready must stay 0.
5. Toggle ena=0 for 5 cycles mid-S_ROUNDS, and separately assert rst mid-message then send "abc". Required: the correct digest with latency extended by exactly 5 cycles; after reset, the "abc" digest is correct, proving the first-block flag and IV reload.
6. Repeat scenarios 1–3 for ROUNDS_PER_CYCLE = 2 and 4. Required: identical digests, with acceptance-to-valid latency of 33 and 17 cycles respectively.
